// File: rtl/i2c_eeprom_slave_if.sv
// I2C pin-level bundle for the EEPROM slave: oversampled SCL/SDA inputs,
// open-drain SDA enable, write-protect strap and status outputs.
interface i2c_eeprom_slave_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;
  logic wp;
  logic wr_pulse;
  logic busy;

  modport slave  (input scl_i, sda_i, wp, output sda_oe, wr_pulse, busy);
  modport master (output scl_i, sda_i, wp, input sda_oe, wr_pulse, busy);
endinterface

// File: rtl/i2c_eeprom_slave.sv
// 24Cxx-style I2C serial EEPROM slave, oversampled on the system clock.
// Byte/page write with in-page wrap, random/current/sequential read, write protect.
module i2c_eeprom_slave #(
  parameter logic [3:0] DEV_ID      = 4'b1010,
  parameter logic [2:0] HW_SEL      = 3'b000,
  parameter int         ADDR_W      = 11,
  parameter int         ADDR_BYTES  = 1,
  parameter int         PAGE_W      = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  i2c_eeprom_slave_if.slave bus
);

  localparam int         K        = ADDR_W - 8*ADDR_BYTES;
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [2:0] SEL_MASK = 3'(3'b111 << K);

  typedef enum logic [3:0] {
    IDLE, CTRL, ACK_C, ADDR_H, ACK_H, ADDR_L, ACK_L,
    WDATA, ACK_W, RDATA, MACK, WAIT
  } state_t;

  // ---------------- input synchronisers and bus-event detection
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  // Idle bus is high, so reset to 1 to avoid phantom edges after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
      r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise =  w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl &  r_scl_d;
  assign w_start    = r_scl_d & w_scl &  r_sda_d & ~w_sda;
  assign w_stop     = r_scl_d & w_scl & ~r_sda_d &  w_sda;

  // ---------------- state and datapath registers
  state_t            r_state, w_state_nxt;
  logic [3:0]        r_bcnt, w_bcnt_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic [3:0]        r_ctrl_lo, w_ctrl_lo_nxt;
  logic [7:0]        r_addr_h, w_addr_h_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic              r_ack_ph, w_ack_ph_nxt;
  logic              r_sda_oe, w_oe_nxt;
  logic              r_wr_pulse, w_wr_pulse_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_mem_we;

  logic [7:0]        r_mem [DEPTH];
  logic [7:0]        w_byte, w_rd_byte;
  logic [18:0]       w_cat;
  logic [ADDR_W-1:0] w_addr_full;
  logic              w_match;

  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_rd_byte = r_mem[r_ptr];
  assign w_match   = (w_byte[7:4] == DEV_ID) &&
                     (((w_byte[3:1] ^ HW_SEL) & SEL_MASK) == 3'b000);
  // Block bits from the control byte sit above the word address.
  assign w_cat       = (ADDR_BYTES == 2) ? {r_ctrl_lo[3:1], r_addr_h, w_byte}
                                         : {8'h00, r_ctrl_lo[3:1], w_byte};
  assign w_addr_full = ADDR_W'(w_cat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bcnt     <= '0;
      r_shift    <= '0;
      r_ctrl_lo  <= '0;
      r_addr_h   <= '0;
      r_ptr      <= '0;
      r_ack_ph   <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_ctrl_lo  <= w_ctrl_lo_nxt;
      r_addr_h   <= w_addr_h_nxt;
      r_ptr      <= w_ptr_nxt;
      r_ack_ph   <= w_ack_ph_nxt;
      r_sda_oe   <= w_oe_nxt;
      r_wr_pulse <= w_wr_pulse_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Array is not reset; writes land at the pre-increment pointer.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_ptr] <= w_byte;
  end

  // ---------------- next-state / output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_bcnt_nxt     = r_bcnt;
    w_shift_nxt    = r_shift;
    w_ctrl_lo_nxt  = r_ctrl_lo;
    w_addr_h_nxt   = r_addr_h;
    w_ptr_nxt      = r_ptr;
    w_ack_ph_nxt   = r_ack_ph;
    w_oe_nxt       = r_sda_oe;
    w_wr_pulse_nxt = 1'b0;
    w_busy_nxt     = r_busy;
    w_mem_we       = 1'b0;

    if (w_stop) begin
      w_state_nxt = IDLE;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = CTRL;
      w_bcnt_nxt   = '0;
      w_ack_ph_nxt = 1'b0;
      w_oe_nxt     = 1'b0;
      w_busy_nxt   = 1'b1;
    end else begin
      case (r_state)
        CTRL, ADDR_H, ADDR_L, WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_bcnt_nxt  = r_bcnt + 4'd1;
            if (r_bcnt == 4'd7) begin
              w_bcnt_nxt   = '0;
              w_ack_ph_nxt = 1'b0;
              case (r_state)
                CTRL: begin
                  w_ctrl_lo_nxt = w_byte[3:0];
                  w_state_nxt   = w_match ? ACK_C : WAIT;
                end
                ADDR_H: begin
                  w_addr_h_nxt = w_byte;
                  w_state_nxt  = ACK_H;
                end
                ADDR_L: begin
                  w_ptr_nxt   = w_addr_full;
                  w_state_nxt = ACK_L;
                end
                default: begin
                  if (bus.wp) begin
                    w_state_nxt = WAIT;
                  end else begin
                    w_mem_we       = 1'b1;
                    w_wr_pulse_nxt = 1'b1;
                    w_ptr_nxt      = {r_ptr[ADDR_W-1:PAGE_W], r_ptr[PAGE_W-1:0] + PAGE_W'(1)};
                    w_state_nxt    = ACK_W;
                  end
                end
              endcase
            end
          end
        end

        // First SCL fall drives the ACK, the second releases it.
        ACK_C, ACK_H, ACK_L, ACK_W: begin
          if (w_scl_fall) begin
            if (!r_ack_ph) begin
              w_oe_nxt     = 1'b1;
              w_ack_ph_nxt = 1'b1;
            end else begin
              w_ack_ph_nxt = 1'b0;
              w_oe_nxt     = 1'b0;
              w_bcnt_nxt   = '0;
              case (r_state)
                ACK_C: begin
                  if (r_ctrl_lo[0]) begin
                    w_state_nxt = RDATA;
                    w_shift_nxt = w_rd_byte;
                    w_oe_nxt    = ~w_rd_byte[7];
                    w_ptr_nxt   = r_ptr + ADDR_W'(1);
                  end else begin
                    w_state_nxt = (ADDR_BYTES == 2) ? ADDR_H : ADDR_L;
                  end
                end
                ACK_H:   w_state_nxt = ADDR_L;
                default: w_state_nxt = WDATA;
              endcase
            end
          end
        end

        // bcnt counts bits already presented to the master.
        RDATA: begin
          if (w_scl_rise) begin
            w_bcnt_nxt = r_bcnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bcnt == 4'd8) begin
              w_oe_nxt    = 1'b0;
              w_bcnt_nxt  = '0;
              w_state_nxt = MACK;
            end else begin
              w_oe_nxt = ~r_shift[~r_bcnt[2:0]];
            end
          end
        end

        MACK: begin
          if (w_scl_rise && w_sda) begin
            w_state_nxt = WAIT;
          end else if (w_scl_fall) begin
            w_state_nxt = RDATA;
            w_bcnt_nxt  = '0;
            w_shift_nxt = w_rd_byte;
            w_oe_nxt    = ~w_rd_byte[7];
            w_ptr_nxt   = r_ptr + ADDR_W'(1);
          end
        end

        default: ;
      endcase
    end
  end

  assign bus.sda_oe   = r_sda_oe;
  assign bus.wr_pulse = r_wr_pulse;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: bit-banged I2C master, vector table
// of byte write / random read pairs, plus page, sequential, bad-ID and reset cases.
module tb_i2c_eeprom_slave;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic sda_m = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   wr_cnt = 0;

  i2c_eeprom_slave_if bus();
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  i2c_eeprom_slave #(
    .DEV_ID(4'b1010), .HW_SEL(3'b000), .ADDR_W(11),
    .ADDR_BYTES(1), .PAGE_W(4), .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (bus.wr_pulse === 1'b1) wr_cnt <= wr_cnt + 1;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
    logic        wp;
    logic        exp_ack;
    logic [7:0]  exp_rd;
  } vec_t;
  vec_t vt [7];

  task automatic hq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; hq(); bus.scl_i = 1'b1; hq(); sda_m = 1'b0; hq(); bus.scl_i = 1'b0; hq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hq(); bus.scl_i = 1'b1; hq(); sda_m = 1'b1; hq();
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; hq(); bus.scl_i = 1'b1; hq(); hq(); bus.scl_i = 1'b0; hq();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; hq(); bus.scl_i = 1'b1; hq(); b = bus.sda_i; hq(); bus.scl_i = 1'b0; hq();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~mack);
  endtask

  // START, control byte for write, word address; leaves the bus after the address ACK.
  task automatic set_addr(input logic [10:0] a, output logic ok);
    logic k1, k2;
    i2c_start();
    wr_byte({4'hA, a[10:8], 1'b0}, k1);
    wr_byte(a[7:0], k2);
    ok = k1 & k2;
  endtask

  task automatic rand_read(input logic [10:0] a, output logic ok, output logic [7:0] d);
    logic k1, k2;
    set_addr(a, k1);
    i2c_start();
    wr_byte({4'hA, a[10:8], 1'b1}, k2);
    rd_byte(1'b0, d);
    i2c_stop();
    ok = k1 & k2;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       ok, k, ka, kd;
    logic [7:0] d;
    int         w0, acks;

    vt[0] = '{11'h005, 8'h3C, 1'b0, 1'b1, 8'h3C};
    vt[1] = '{11'h123, 8'hA5, 1'b0, 1'b1, 8'hA5};
    vt[2] = '{11'h7F0, 8'h5A, 1'b0, 1'b1, 8'h5A};
    vt[3] = '{11'h005, 8'hFF, 1'b1, 1'b0, 8'h3C};
    vt[4] = '{11'h400, 8'h00, 1'b0, 1'b1, 8'h00};
    vt[5] = '{11'h123, 8'h11, 1'b1, 1'b0, 8'hA5};
    vt[6] = '{11'h7FF, 8'hC3, 1'b0, 1'b1, 8'hC3};

    bus.scl_i = 1'b1;
    bus.wp    = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    hq(); hq();
    chk("reset sda_oe", bus.sda_oe, 1'b0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset wr_pulse", bus.wr_pulse, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    hq();

    // START/STOP only
    i2c_start();
    chk("start busy", bus.busy, 1'b1);
    chk("start no ack", bus.sda_oe, 1'b0);
    i2c_stop();
    hq();
    chk("stop busy", bus.busy, 1'b0);

    // 18-byte page write from 0x0E wraps inside page 0x00..0x0F
    w0 = wr_cnt;
    acks = 0;
    i2c_start();
    wr_byte(8'hA0, k); acks += int'(k);
    wr_byte(8'h0E, k); acks += int'(k);
    for (int i = 1; i <= 18; i++) begin
      wr_byte(8'(8'h40 + i), k);
      acks += int'(k);
    end
    i2c_stop();
    hq();
    chk("page acks", acks, 20);
    chk("page wr_pulses", wr_cnt - w0, 18);
    set_addr(11'h000, ok);
    i2c_start();
    wr_byte(8'hA1, k);
    chk("page rd addr ack", {ok, k}, 2'b11);
    for (int a = 0; a < 16; a++) begin
      rd_byte(a != 15, d);
      chk($sformatf("page rd %0h", a), d, 8'(8'h43 + a));
    end
    i2c_stop();

    // byte write / random read vectors
    for (int v = 0; v < 7; v++) begin
      w0 = wr_cnt;
      i2c_start();
      wr_byte({4'hA, vt[v].addr[10:8], 1'b0}, k);
      wr_byte(vt[v].addr[7:0], ka);
      bus.wp = vt[v].wp;
      wr_byte(vt[v].data, kd);
      bus.wp = 1'b0;
      i2c_stop();
      hq();
      chk($sformatf("vec%0d acks", v), {k, ka, kd}, {2'b11, vt[v].exp_ack});
      chk($sformatf("vec%0d wr_pulses", v), wr_cnt - w0, {31'd0, vt[v].exp_ack});
      rand_read(vt[v].addr, ok, d);
      chk($sformatf("vec%0d rd ack", v), ok, 1'b1);
      chk($sformatf("vec%0d rd data", v), d, vt[v].exp_rd);
    end

    // sequential read across the top of the array
    set_addr(11'h7FF, ok);
    i2c_start();
    wr_byte(8'hAF, k);
    chk("seq acks", {ok, k}, 2'b11);
    rd_byte(1'b1, d); chk("seq rd 7FF", d, 8'hC3);
    rd_byte(1'b1, d); chk("seq rd 000", d, 8'h43);
    rd_byte(1'b0, d); chk("seq rd 001", d, 8'h44);
    chk("seq nack release", bus.sda_oe, 1'b0);
    i2c_stop();
    hq();
    chk("seq stop busy", bus.busy, 1'b0);

    // wrong device ID is ignored until STOP
    w0 = wr_cnt;
    i2c_start();
    wr_byte(8'hB0, k);  chk("badid ctrl nack", k, 1'b0);
    wr_byte(8'h05, k);  chk("badid addr nack", k, 1'b0);
    wr_byte(8'h77, k);  chk("badid data nack", k, 1'b0);
    chk("badid busy", bus.busy, 1'b1);
    i2c_stop();
    hq();
    chk("badid wr_pulses", wr_cnt - w0, 0);
    rand_read(11'h005, ok, d);
    chk("badid mem unchanged", d, 8'h3C);

    // reset while driving a read bit, then current-address read from 0
    set_addr(11'h005, ok);
    i2c_start();
    wr_byte(8'hA1, k);
    chk("rst pre acks", {ok, k}, 2'b11);
    chk("rst pre drive", bus.sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst sda_oe", bus.sda_oe, 1'b0);
    chk("rst busy", bus.busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    hq();
    i2c_start();
    wr_byte(8'hA1, k);
    chk("cur rd ack", k, 1'b1);
    rd_byte(1'b0, d);
    chk("cur rd data", d, 8'h43);
    i2c_stop();
    hq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
